sdram_rd_engine: RTL and testbench
==================================

SDRAM_RD_ENGINE -- requirements
Module: sdram_rd_engine

Interface
REQ-001 Parameters SHALL be: ROW_W, default 13, row/address width; COL_W, default 9, column width; DQ_W, default 16, data width; BL, default 4, burst length (power of 2, 1..8); CL, default 3, CAS latency (2..3); T_RCD, default 3, NOP cycles after ACT; T_RP, default 3, NOP cycles after PRE.
REQ-002 sclk  in  1  clock.
REQ-003 reset  in  1  reset, asynchronous, active-low.
REQ-004 rd_trig  in  1  start-request pulse; sampled only in IDLE.
REQ-005 start_row  in  ROW_W  first row; captured on accepted rd_trig.
REQ-006 num_rows  in  ROW_W  rows to read; captured on accepted rd_trig.
REQ-007 bank_sel  in  2  bank; captured on accepted rd_trig.
REQ-008 rd_en  in  1  bus grant from arbiter.
REQ-009 ref_req  in  1  refresh request from refresh block.
REQ-010 sdram_dq  in  DQ_W  SDRAM read data.
REQ-011 rd_req  out  1  bus request; high exactly while in REQ.
REQ-012 flag_rd_end  out  1  one-cycle pulse on bus release (refresh yield or completion).
REQ-013 rd_done  out  1  one-cycle pulse on completion of all rows.
REQ-014 rd_cmd  out  4  registered SDRAM command {CS,RAS,CAS,WE}: NOP 0111, PRE 0010, ACT 0011, RD 0101.
REQ-015 rd_addr  out  ROW_W  registered address, aligned with rd_cmd.
REQ-016 bank_addr  out  2  registered captured bank_sel.
REQ-017 rd_data  out  DQ_W  registered sdram_dq.
REQ-018 rd_data_vld  out  1  rd_data valid.

Function
REQ-019 States SHALL be one-hot IDLE, REQ, ACT, RD, PRE.
REQ-020 IDLE->REQ on rd_trig with num_rows!=0; rd_trig with num_rows==0 or outside IDLE SHALL be ignored.
REQ-021 REQ->ACT when rd_en=1; otherwise remain in REQ.
REQ-022 ACT: issue one CMD_ACT with rd_addr=current row, then T_RCD NOPs, then ->RD.
REQ-023 RD: issue CMD_RD with rd_addr={zero-pad, A10=0, column} every BL cycles, with BL-1 NOPs between; column starts at 0 for each new row and advances by BL per burst, wrapping at 2^COL_W.
REQ-024 Decision point SHALL be the last cycle of each burst, priority: (a) last burst of last row -> PRE (final); (b) ref_req=1 -> PRE (yield); (c) last burst of row -> PRE (row change); (d) otherwise next burst.
REQ-025 PRE: issue one CMD_PRE with rd_addr[10]=1 and all other address bits 0, then T_RP NOPs; on exit: final -> IDLE with rd_done and flag_rd_end pulsing together; yield -> REQ with flag_rd_end pulse; row change -> ACT with row+1 (ROW_W wrap).
REQ-026 After a yield, reading SHALL resume at the same row and the column following the last issued burst; no burst is repeated or skipped.
REQ-027 ref_req asserted outside RD SHALL NOT alter the sequence; it is evaluated only at REQ-024 decision points.
REQ-028 rd_data SHALL equal sdram_dq delayed one cycle; rd_data_vld SHALL be high for BL consecutive cycles starting CL+1 cycles after each cycle in which rd_cmd=CMD_RD, via a shift pipeline independent of state (it completes after PRE/IDLE).
REQ-029 Total rd_data_vld cycles per job SHALL equal num_rows*2^COL_W.
REQ-030 rd_cmd SHALL be NOP in IDLE and REQ; rd_addr SHALL hold its last value when not issuing a command.

Reset
REQ-031 On reset low: state=IDLE, rd_cmd=NOP, rd_addr=0, bank_addr=0, rd_req=0, flag_rd_end=0, rd_done=0, rd_data=0, rd_data_vld=0, pipeline and counters cleared.
REQ-032 Reset mid-job SHALL abandon the job without issuing PRE; the next job restarts from its own start_row.

Verification
REQ-033 Defaults, start_row=5, num_rows=1, bank_sel=2, rd_en tied 1 -> ACT row 5, 128 RD commands at cols 0,4,...,508, PRE with addr 0x400, rd_done once, 512 vld cycles, bank_addr=2.
REQ-034 num_rows=2, start_row=8190 -> rows 8190 then 8191, one intermediate PRE+ACT, rd_done after 1024 vld cycles.
REQ-035 ref_req pulsed during burst at col 100 -> PRE after col 100 burst, flag_rd_end, rd_req high; grant after 20 cycles -> ACT same row, next RD col 104, no rd_done until row end.
REQ-036 rd_trig with num_rows=0, and rd_trig during RD -> no state change, no extra command.
REQ-037 CL=2, BL=8 build -> first rd_data_vld 3 cycles after first RD, 8 cycles per burst, 64 RD per row.
REQ-038 Reset asserted mid-RD -> all outputs at reset values next cycle; new rd_trig starts a clean ACT.

Source files
------------

// File: rtl/sdram_rd_engine.sv
// SDRAM read engine: requests the bus, then reads whole rows as column bursts.
// It yields the bus to refresh at burst boundaries and resumes where it stopped.
module sdram_rd_engine #(
    parameter int unsigned ROW_W = 13,
    parameter int unsigned COL_W = 9,
    parameter int unsigned DQ_W  = 16,
    parameter int unsigned BL    = 4,
    parameter int unsigned CL    = 3,
    parameter int unsigned T_RCD = 3,
    parameter int unsigned T_RP  = 3
) (
    input  logic             sclk,
    input  logic             reset,
    input  logic             rd_trig,
    input  logic [ROW_W-1:0] start_row,
    input  logic [ROW_W-1:0] num_rows,
    input  logic [1:0]       bank_sel,
    input  logic             rd_en,
    input  logic             ref_req,
    input  logic [DQ_W-1:0]  sdram_dq,
    output logic             rd_req,
    output logic             flag_rd_end,
    output logic             rd_done,
    output logic [3:0]       rd_cmd,
    output logic [ROW_W-1:0] rd_addr,
    output logic [1:0]       bank_addr,
    output logic [DQ_W-1:0]  rd_data,
    output logic             rd_data_vld
);

    localparam int unsigned CW = 4;
    localparam int unsigned PW = CL + BL - 1;

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;

    localparam logic [CW-1:0]    TRCD_LAST = CW'(T_RCD);
    localparam logic [CW-1:0]    TRP_LAST  = CW'(T_RP);
    localparam logic [CW-1:0]    BL_LAST   = CW'(BL - 1);
    localparam logic [COL_W-1:0] LAST_COL  = COL_W'((1 << COL_W) - BL);
    localparam logic [ROW_W-1:0] PRE_ADDR  = ROW_W'(1024);

    typedef enum logic [4:0] {
        IDLE = 5'b00001,
        REQ  = 5'b00010,
        ACT  = 5'b00100,
        RD   = 5'b01000,
        PRE  = 5'b10000
    } state_t;

    typedef enum logic [1:0] {
        PK_FINAL = 2'd0,
        PK_YIELD = 2'd1,
        PK_ROW   = 2'd2
    } pre_kind_t;

    state_t           state;
    pre_kind_t        pre_kind;
    logic [ROW_W-1:0] row;
    logic [ROW_W-1:0] rows_left;
    logic [COL_W-1:0] col;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    bcnt;
    logic [PW-1:0]    vld_sr;

    logic [COL_W-1:0] col_nxt;
    logic             last_burst;

    assign col_nxt    = col + COL_W'(BL);
    assign last_burst = (col == LAST_COL);

    // Read address: column in the low bits, A10 forced low (no auto-precharge).
    function automatic logic [ROW_W-1:0] col_addr(input logic [COL_W-1:0] c);
        logic [ROW_W-1:0] a;
        a     = ROW_W'(c);
        a[10] = 1'b0;
        return a;
    endfunction

    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            pre_kind    <= PK_FINAL;
            row         <= '0;
            rows_left   <= '0;
            col         <= '0;
            cnt         <= '0;
            bcnt        <= '0;
            vld_sr      <= '0;
            rd_req      <= 1'b0;
            flag_rd_end <= 1'b0;
            rd_done     <= 1'b0;
            rd_cmd      <= CMD_NOP;
            rd_addr     <= '0;
            bank_addr   <= '0;
            rd_data     <= '0;
            rd_data_vld <= 1'b0;
        end else begin
            // Data path runs independently of the FSM so trailing bursts drain.
            rd_data     <= sdram_dq;
            vld_sr      <= {vld_sr[PW-2:0], (rd_cmd == CMD_RD)};
            rd_data_vld <= |vld_sr[PW-1:CL-1];

            flag_rd_end <= 1'b0;
            rd_done     <= 1'b0;
            rd_cmd      <= CMD_NOP;

            case (state)
                IDLE: begin
                    if (rd_trig && (num_rows != '0)) begin
                        row       <= start_row;
                        rows_left <= num_rows;
                        bank_addr <= bank_sel;
                        col       <= '0;
                        rd_req    <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (rd_en) begin
                        rd_req  <= 1'b0;
                        rd_cmd  <= CMD_ACT;
                        rd_addr <= row;
                        cnt     <= '0;
                        state   <= ACT;
                    end
                end
                ACT: begin
                    if (cnt == TRCD_LAST) begin
                        rd_cmd  <= CMD_RD;
                        rd_addr <= col_addr(col);
                        bcnt    <= '0;
                        state   <= RD;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RD: begin
                    if (bcnt == BL_LAST) begin
                        // Column/row bookkeeping moves past this burst whatever comes next.
                        col <= col_nxt;
                        if (last_burst) begin
                            row       <= row + ROW_W'(1);
                            rows_left <= rows_left - ROW_W'(1);
                        end
                        if ((last_burst && (rows_left == ROW_W'(1))) || ref_req || last_burst) begin
                            rd_cmd  <= CMD_PRE;
                            rd_addr <= PRE_ADDR;
                            cnt     <= '0;
                            state   <= PRE;
                            if (last_burst && (rows_left == ROW_W'(1))) begin
                                pre_kind <= PK_FINAL;
                            end else if (ref_req) begin
                                pre_kind <= PK_YIELD;
                            end else begin
                                pre_kind <= PK_ROW;
                            end
                        end else begin
                            rd_cmd  <= CMD_RD;
                            rd_addr <= col_addr(col_nxt);
                            bcnt    <= '0;
                        end
                    end else begin
                        bcnt <= bcnt + CW'(1);
                    end
                end
                PRE: begin
                    if (cnt == TRP_LAST) begin
                        case (pre_kind)
                            PK_YIELD: begin
                                flag_rd_end <= 1'b1;
                                rd_req      <= 1'b1;
                                state       <= REQ;
                            end
                            PK_ROW: begin
                                rd_cmd  <= CMD_ACT;
                                rd_addr <= row;
                                cnt     <= '0;
                                state   <= ACT;
                            end
                            default: begin
                                flag_rd_end <= 1'b1;
                                rd_done     <= 1'b1;
                                state       <= IDLE;
                            end
                        endcase
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_rd_engine.sv
// Directed bench for sdram_rd_engine: default build plus a CL=2/BL=8 build.
module tb_sdram_rd_engine;

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;

    logic        sclk = 1'b0;
    logic        reset = 1'b0;
    logic        rd_trig = 1'b0;
    logic [12:0] start_row = '0;
    logic [12:0] num_rows = '0;
    logic [1:0]  bank_sel = '0;
    logic        rd_en = 1'b1;
    logic        ref_req = 1'b0;
    logic [15:0] sdram_dq = '0;
    logic        rd_req, flag_rd_end, rd_done, rd_data_vld;
    logic [3:0]  rd_cmd;
    logic [12:0] rd_addr;
    logic [1:0]  bank_addr;
    logic [15:0] rd_data;

    logic        rd_trig2 = 1'b0;
    logic        rd_req2, flag_rd_end2, rd_done2, rd_data_vld2;
    logic [3:0]  rd_cmd2;
    logic [12:0] rd_addr2;
    logic [1:0]  bank_addr2;
    logic [15:0] rd_data2;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int n_act = 0, n_pre = 0, n_done = 0, n_flag = 0, n_req = 0;
    int n_done2 = 0, n_flag2 = 0, n_req2 = 0;
    logic [12:0] last_pre = '0;
    logic [12:0] rd_q[$];
    logic [12:0] act_q[$];
    int          rd_cyc_q[$];
    int          vld_cyc_q[$];
    logic [12:0] rd2_q[$];
    int          rd2_cyc_q[$];
    int          vld2_cyc_q[$];

    always #5 sclk = ~sclk;

    sdram_rd_engine dut (
        .sclk(sclk), .reset(reset), .rd_trig(rd_trig), .start_row(start_row),
        .num_rows(num_rows), .bank_sel(bank_sel), .rd_en(rd_en), .ref_req(ref_req),
        .sdram_dq(sdram_dq), .rd_req(rd_req), .flag_rd_end(flag_rd_end),
        .rd_done(rd_done), .rd_cmd(rd_cmd), .rd_addr(rd_addr), .bank_addr(bank_addr),
        .rd_data(rd_data), .rd_data_vld(rd_data_vld)
    );

    sdram_rd_engine #(.CL(2), .BL(8)) dut2 (
        .sclk(sclk), .reset(reset), .rd_trig(rd_trig2), .start_row(13'd11),
        .num_rows(13'd1), .bank_sel(2'd3), .rd_en(1'b1), .ref_req(1'b0),
        .sdram_dq(sdram_dq), .rd_req(rd_req2), .flag_rd_end(flag_rd_end2),
        .rd_done(rd_done2), .rd_cmd(rd_cmd2), .rd_addr(rd_addr2), .bank_addr(bank_addr2),
        .rd_data(rd_data2), .rd_data_vld(rd_data_vld2)
    );

    // Event recorder, sampled on the falling edge.
    always @(negedge sclk) begin
        cyc = cyc + 1;
        if (rd_cmd === CMD_RD) begin rd_q.push_back(rd_addr); rd_cyc_q.push_back(cyc); end
        if (rd_cmd === CMD_ACT) begin n_act = n_act + 1; act_q.push_back(rd_addr); end
        if (rd_cmd === CMD_PRE) begin n_pre = n_pre + 1; last_pre = rd_addr; end
        if (rd_data_vld === 1'b1) vld_cyc_q.push_back(cyc);
        if (rd_done === 1'b1) n_done = n_done + 1;
        if (flag_rd_end === 1'b1) n_flag = n_flag + 1;
        if (rd_req === 1'b1) n_req = n_req + 1;
        if (rd_cmd2 === CMD_RD) begin rd2_q.push_back(rd_addr2); rd2_cyc_q.push_back(cyc); end
        if (rd_data_vld2 === 1'b1) vld2_cyc_q.push_back(cyc);
        if (rd_done2 === 1'b1) n_done2 = n_done2 + 1;
        if (flag_rd_end2 === 1'b1) n_flag2 = n_flag2 + 1;
        if (rd_req2 === 1'b1) n_req2 = n_req2 + 1;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(negedge sclk); #1; end
    endtask

    // sel: 0 done, 1 flag, 2 act, 3 rd commands, 4 done (CL2/BL8 build)
    task automatic wait_evt(input int sel, input int target, input int budget, output bit ok);
        int v;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            case (sel)
                0: v = n_done;
                1: v = n_flag;
                2: v = n_act;
                3: v = rd_q.size();
                default: v = n_done2;
            endcase
            if (v >= target) begin ok = 1'b1; break; end
        end
    endtask

    task automatic start_job(input logic [12:0] sr, input logic [12:0] nr, input logic [1:0] bk);
        start_row = sr; num_rows = nr; bank_sel = bk; rd_trig = 1'b1;
        tick();
        rd_trig = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(3);
        checks++; if (rd_cmd !== CMD_NOP) begin errors++; $display("FAIL reset_cmd: got %b expected %b", rd_cmd, CMD_NOP); end
        checks++; if (rd_addr !== 13'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", rd_addr); end
        checks++; if (bank_addr !== 2'd0) begin errors++; $display("FAIL reset_bank: got %0d expected 0", bank_addr); end
        checks++; if ({rd_req, flag_rd_end, rd_done, rd_data_vld} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {rd_req, flag_rd_end, rd_done, rd_data_vld}); end
        checks++; if (rd_data !== 16'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", rd_data); end
        reset = 1'b1;
        tick(2);
    endtask

    task automatic test_single_row();
        int r0 = rd_q.size(), a0 = n_act, p0 = n_pre, d0 = n_done, f0 = n_flag, q0 = n_req, v0 = vld_cyc_q.size();
        int bad = 0;
        bit ok;
        start_job(13'd5, 13'd1, 2'd2);
        wait_evt(0, d0 + 1, 2000, ok);
        tick(5);
        checks++; if (!ok) begin errors++; $display("FAIL single_done_timeout: got 0 expected 1"); end
        checks++; if (n_act - a0 !== 1) begin errors++; $display("FAIL single_act_cnt: got %0d expected 1", n_act - a0); end
        checks++; if (act_q[a0] !== 13'd5) begin errors++; $display("FAIL single_act_row: got %0d expected 5", act_q[a0]); end
        checks++; if (rd_q.size() - r0 !== 128) begin errors++; $display("FAIL single_rd_cnt: got %0d expected 128", rd_q.size() - r0); end
        for (int i = 0; i < 128 && r0 + i < rd_q.size(); i++) if (rd_q[r0 + i] !== 13'(i * 4)) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL single_rd_cols: got %0d wrong expected 0 wrong", bad); end
        checks++; if (n_pre - p0 !== 1) begin errors++; $display("FAIL single_pre_cnt: got %0d expected 1", n_pre - p0); end
        checks++; if (last_pre !== 13'h400) begin errors++; $display("FAIL single_pre_addr: got %h expected 400", last_pre); end
        checks++; if (n_done - d0 !== 1) begin errors++; $display("FAIL single_done_cnt: got %0d expected 1", n_done - d0); end
        checks++; if (n_flag - f0 !== 1) begin errors++; $display("FAIL single_flag_cnt: got %0d expected 1", n_flag - f0); end
        checks++; if (n_req - q0 !== 1) begin errors++; $display("FAIL single_req_cycles: got %0d expected 1", n_req - q0); end
        checks++; if (vld_cyc_q.size() - v0 !== 512) begin errors++; $display("FAIL single_vld_cnt: got %0d expected 512", vld_cyc_q.size() - v0); end
        checks++; if (vld_cyc_q[v0] - rd_cyc_q[r0] !== 4) begin errors++; $display("FAIL single_latency: got %0d expected 4", vld_cyc_q[v0] - rd_cyc_q[r0]); end
        checks++; if (bank_addr !== 2'd2) begin errors++; $display("FAIL single_bank: got %0d expected 2", bank_addr); end
        checks++; if (rd_cmd !== CMD_NOP) begin errors++; $display("FAIL single_idle_cmd: got %b expected %b", rd_cmd, CMD_NOP); end
    endtask

    task automatic test_data();
        logic [15:0] pats [4] = '{16'hA5C3, 16'h0000, 16'hFFFF, 16'h1234};
        for (int i = 0; i < 4; i++) begin
            sdram_dq = pats[i];
            tick();
            checks++; if (rd_data !== pats[i]) begin errors++; $display("FAIL data_%0d: got %h expected %h", i, rd_data, pats[i]); end
            checks++; if (rd_data2 !== pats[i]) begin errors++; $display("FAIL data2_%0d: got %h expected %h", i, rd_data2, pats[i]); end
        end
    endtask

    task automatic test_two_rows();
        int r0 = rd_q.size(), a0 = n_act, p0 = n_pre, d0 = n_done, v0 = vld_cyc_q.size();
        int bad = 0;
        bit ok;
        start_job(13'd8190, 13'd2, 2'd1);
        wait_evt(0, d0 + 1, 3000, ok);
        tick(5);
        checks++; if (!ok) begin errors++; $display("FAIL two_done_timeout: got 0 expected 1"); end
        checks++; if (n_act - a0 !== 2) begin errors++; $display("FAIL two_act_cnt: got %0d expected 2", n_act - a0); end
        checks++; if (act_q[a0] !== 13'd8190) begin errors++; $display("FAIL two_row0: got %0d expected 8190", act_q[a0]); end
        checks++; if (act_q[a0 + 1] !== 13'd8191) begin errors++; $display("FAIL two_row1: got %0d expected 8191", act_q[a0 + 1]); end
        checks++; if (n_pre - p0 !== 2) begin errors++; $display("FAIL two_pre_cnt: got %0d expected 2", n_pre - p0); end
        checks++; if (rd_q.size() - r0 !== 256) begin errors++; $display("FAIL two_rd_cnt: got %0d expected 256", rd_q.size() - r0); end
        for (int i = 0; i < 256 && r0 + i < rd_q.size(); i++) if (rd_q[r0 + i] !== 13'((i % 128) * 4)) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL two_rd_cols: got %0d wrong expected 0 wrong", bad); end
        checks++; if (vld_cyc_q.size() - v0 !== 1024) begin errors++; $display("FAIL two_vld_cnt: got %0d expected 1024", vld_cyc_q.size() - v0); end
        checks++; if (n_done - d0 !== 1) begin errors++; $display("FAIL two_done_cnt: got %0d expected 1", n_done - d0); end
    endtask

    task automatic test_yield();
        int r0 = rd_q.size(), a0 = n_act, d0 = n_done, f0 = n_flag, v0 = vld_cyc_q.size();
        int bad = 0;
        bit ok;
        rd_en = 1'b1;
        start_job(13'd20, 13'd1, 2'd0);
        wait_evt(3, r0 + 26, 500, ok);
        checks++; if (!ok) begin errors++; $display("FAIL yield_col100_timeout: got 0 expected 1"); end
        checks++; if (rd_q[r0 + 25] !== 13'd100) begin errors++; $display("FAIL yield_col100: got %0d expected 100", rd_q[r0 + 25]); end
        ref_req = 1'b1;
        rd_en = 1'b0;
        tick(4);
        ref_req = 1'b0;
        wait_evt(1, f0 + 1, 50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL yield_flag_timeout: got 0 expected 1"); end
        checks++; if (rd_req !== 1'b1) begin errors++; $display("FAIL yield_rd_req: got %b expected 1", rd_req); end
        checks++; if (rd_q.size() - r0 !== 26) begin errors++; $display("FAIL yield_rd_before_pre: got %0d expected 26", rd_q.size() - r0); end
        checks++; if (n_done !== d0) begin errors++; $display("FAIL yield_no_done: got %0d expected %0d", n_done, d0); end
        tick(20);
        checks++; if (n_act - a0 !== 1) begin errors++; $display("FAIL yield_wait_act: got %0d expected 1", n_act - a0); end
        checks++; if (rd_req !== 1'b1) begin errors++; $display("FAIL yield_req_held: got %b expected 1", rd_req); end
        rd_en = 1'b1;
        wait_evt(2, a0 + 2, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL yield_act_timeout: got 0 expected 1"); end
        checks++; if (act_q[a0 + 1] !== 13'd20) begin errors++; $display("FAIL yield_resume_row: got %0d expected 20", act_q[a0 + 1]); end
        wait_evt(3, r0 + 27, 20, ok);
        checks++; if (rd_q[r0 + 26] !== 13'd104) begin errors++; $display("FAIL yield_resume_col: got %0d expected 104", rd_q[r0 + 26]); end
        wait_evt(0, d0 + 1, 1000, ok);
        tick(5);
        checks++; if (!ok) begin errors++; $display("FAIL yield_done_timeout: got 0 expected 1"); end
        for (int i = 0; i < 128 && r0 + i < rd_q.size(); i++) if (rd_q[r0 + i] !== 13'(i * 4)) bad++;
        checks++; if (rd_q.size() - r0 !== 128 || bad !== 0) begin errors++; $display("FAIL yield_cols: got %0d rds %0d wrong expected 128 rds 0 wrong", rd_q.size() - r0, bad); end
        checks++; if (n_flag - f0 !== 2) begin errors++; $display("FAIL yield_flag_cnt: got %0d expected 2", n_flag - f0); end
        checks++; if (vld_cyc_q.size() - v0 !== 512) begin errors++; $display("FAIL yield_vld_cnt: got %0d expected 512", vld_cyc_q.size() - v0); end
    endtask

    task automatic test_ignored_trig();
        int a0 = n_act, q0 = n_req, r0, d0;
        int bad = 0;
        bit ok;
        ref_req = 1'b1;
        tick();
        ref_req = 1'b0;
        start_job(13'd100, 13'd0, 2'd3);
        tick(10);
        checks++; if (n_act !== a0) begin errors++; $display("FAIL ign_zero_act: got %0d expected %0d", n_act, a0); end
        checks++; if (n_req !== q0) begin errors++; $display("FAIL ign_zero_req: got %0d expected %0d", n_req, q0); end
        checks++; if (bank_addr !== 2'd0) begin errors++; $display("FAIL ign_zero_bank: got %0d expected 0", bank_addr); end
        r0 = rd_q.size(); d0 = n_done;
        start_job(13'd3, 13'd1, 2'd1);
        wait_evt(3, r0 + 5, 100, ok);
        start_job(13'd100, 13'd5, 2'd2);
        wait_evt(0, d0 + 1, 1000, ok);
        tick(5);
        checks++; if (!ok) begin errors++; $display("FAIL ign_done_timeout: got 0 expected 1"); end
        checks++; if (n_act - a0 !== 1 || act_q[a0] !== 13'd3) begin errors++; $display("FAIL ign_act: got %0d acts row %0d expected 1 acts row 3", n_act - a0, act_q[a0]); end
        for (int i = 0; i < 128 && r0 + i < rd_q.size(); i++) if (rd_q[r0 + i] !== 13'(i * 4)) bad++;
        checks++; if (rd_q.size() - r0 !== 128 || bad !== 0) begin errors++; $display("FAIL ign_cols: got %0d rds %0d wrong expected 128 rds 0 wrong", rd_q.size() - r0, bad); end
        checks++; if (bank_addr !== 2'd1) begin errors++; $display("FAIL ign_bank: got %0d expected 1", bank_addr); end
        tick(10);
        checks++; if (rd_cmd !== CMD_NOP || rd_req !== 1'b0) begin errors++; $display("FAIL ign_idle: got cmd %b req %b expected cmd 0111 req 0", rd_cmd, rd_req); end
    endtask

    task automatic test_cl2_bl8();
        int r0 = rd2_q.size(), v0 = vld2_cyc_q.size(), d0 = n_done2, f0 = n_flag2, q0 = n_req2;
        bit ok;
        rd_trig2 = 1'b1;
        tick();
        rd_trig2 = 1'b0;
        wait_evt(4, d0 + 1, 2000, ok);
        tick(5);
        checks++; if (!ok) begin errors++; $display("FAIL b8_done_timeout: got 0 expected 1"); end
        checks++; if (rd2_q.size() - r0 !== 64) begin errors++; $display("FAIL b8_rd_cnt: got %0d expected 64", rd2_q.size() - r0); end
        checks++; if (rd2_q[r0 + 1] !== 13'd8 || rd2_q[r0 + 63] !== 13'd504) begin errors++; $display("FAIL b8_cols: got %0d,%0d expected 8,504", rd2_q[r0 + 1], rd2_q[r0 + 63]); end
        checks++; if (vld2_cyc_q[v0] - rd2_cyc_q[r0] !== 3) begin errors++; $display("FAIL b8_latency: got %0d expected 3", vld2_cyc_q[v0] - rd2_cyc_q[r0]); end
        checks++; if (vld2_cyc_q[v0 + 7] - vld2_cyc_q[v0] !== 7 || vld2_cyc_q[v0 + 8] !== rd2_cyc_q[r0 + 1] + 3) begin errors++; $display("FAIL b8_burst_len: got span %0d expected 7", vld2_cyc_q[v0 + 7] - vld2_cyc_q[v0]); end
        checks++; if (vld2_cyc_q.size() - v0 !== 512) begin errors++; $display("FAIL b8_vld_cnt: got %0d expected 512", vld2_cyc_q.size() - v0); end
        checks++; if (n_flag2 - f0 !== 1 || n_req2 - q0 !== 1 || bank_addr2 !== 2'd3) begin errors++; $display("FAIL b8_misc: got flag %0d req %0d bank %0d expected 1 1 3", n_flag2 - f0, n_req2 - q0, bank_addr2); end
    endtask

    task automatic test_reset_mid();
        int r0 = rd_q.size(), p0 = n_pre, a0, d0;
        int bad = 0;
        bit ok;
        sdram_dq = 16'hBEEF;
        start_job(13'd7, 13'd1, 2'd3);
        wait_evt(3, r0 + 11, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rst_mid_reach_timeout: got 0 expected 1"); end
        reset = 1'b0;
        #1;
        checks++; if (rd_cmd !== CMD_NOP || rd_addr !== 13'd0 || bank_addr !== 2'd0) begin errors++; $display("FAIL rst_mid_cmd: got cmd %b addr %0d bank %0d expected 0111 0 0", rd_cmd, rd_addr, bank_addr); end
        checks++; if ({rd_req, flag_rd_end, rd_done, rd_data_vld} !== 4'b0000 || rd_data !== 16'd0) begin errors++; $display("FAIL rst_mid_flags: got %b data %h expected 0000 data 0", {rd_req, flag_rd_end, rd_done, rd_data_vld}, rd_data); end
        tick(3);
        reset = 1'b1;
        tick(2);
        checks++; if (n_pre !== p0) begin errors++; $display("FAIL rst_mid_no_pre: got %0d expected %0d", n_pre, p0); end
        checks++; if (rd_data_vld !== 1'b0) begin errors++; $display("FAIL rst_mid_vld: got %b expected 0", rd_data_vld); end
        a0 = n_act; d0 = n_done; r0 = rd_q.size();
        start_job(13'd9, 13'd1, 2'd0);
        wait_evt(0, d0 + 1, 1000, ok);
        tick(5);
        checks++; if (!ok) begin errors++; $display("FAIL rst_new_done_timeout: got 0 expected 1"); end
        checks++; if (n_act - a0 !== 1 || act_q[a0] !== 13'd9) begin errors++; $display("FAIL rst_new_act: got %0d acts row %0d expected 1 acts row 9", n_act - a0, act_q[a0]); end
        for (int i = 0; i < 128 && r0 + i < rd_q.size(); i++) if (rd_q[r0 + i] !== 13'(i * 4)) bad++;
        checks++; if (rd_q.size() - r0 !== 128 || bad !== 0) begin errors++; $display("FAIL rst_new_cols: got %0d rds %0d wrong expected 128 rds 0 wrong", rd_q.size() - r0, bad); end
    endtask

    initial begin
        test_reset();
        test_single_row();
        test_data();
        test_two_rows();
        test_yield();
        test_ignored_trig();
        test_cl2_bl8();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
